piccolo128_dec_iter: RTL and testbench
======================================

Name: piccolo128_dec_iter

Overview:
Iterative Piccolo-128 decryption core: one 64-bit ciphertext block and one 128-bit key are accepted per start; one round is computed per clock, giving 31 rounds.
It is the decrypt counterpart of the Piccolo-128 encryption round datapath in this codebase and uses the same [0:N] big-endian bit numbering. Word Xn = data[16n:16n+15] and key word kn = keyin[16n:16n+15].
It sits behind a simple start/done handshake, so a controller can feed blocks back-to-back.

Parameters:
ROUNDS, 31, number of Piccolo-128 rounds; fixed; any other value is unsupported.
KEXP_CYCLES, 7, number of forward key-permutation steps needed to reach the final key state; fixed.

Ports:
clk  in  1  system clock; rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
keyin  in  [0:127]  key k0..k7; sampled on the accepted start edge.
ciphertext  in  [0:63]  block to decrypt; sampled on the accepted start edge.
busy  out  1  high in KEXP and ROUND states.
done  out  1  one-cycle pulse when plaintext becomes valid.
plaintext  out  [0:63]  result; holds its value until the next done pulse.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, plaintext=0, all internal registers 0. rst overrides everything, including mid-operation: the block returns to IDLE and no done pulse follows.
- State machine: IDLE -> KEXP -> ROUND -> IDLE.
- IDLE, start=1 (edge E0):
  - Latch key state K=k0..k7.
  - Latch D = ciphertext with X1^=wk2 and X3^=wk3, where wk2={k4[0:7],k7[8:15]} and wk3={k7[0:7],k4[8:15]}.
  - cnt=0; next state KEXP.
  - start=1 in any other state is ignored.
- KEXP: 7 cycles (E1..E7). Each cycle applies the forward permutation K <= (k2,k1,k6,k7,k0,k3,k4,k5). At E7: next state ROUND, j=0.
- ROUND: round j=0..30 at edges E8..E38. Let i=60-2j and c=31-j (5 bits).
  - Constants:
    - cA = {c,00000,c,0} ^ 16'h6547
    - cB = {0,c,00000,c} ^ 16'hA98B
  - Round keys:
    - rkA = K[(i+2) mod 8] ^ cA
    - rkB = K[(i+3) mod 8] ^ cB
  - Key selection:
    - j even: X1 ^= F(X0)^rkA and X3 ^= F(X2)^rkB.
    - j odd: the two keys are swapped (X1 uses rkB, X3 uses rkA).
  - Round permutation: for j<30, D <= RP(D), where RP reorders bytes (b0..b7) -> (b2,b7,b4,b1,b6,b3,b0,b5).
  - Inverse key permutation: after the round, if (i+2) mod 8 == 0, apply K <= (k4,k1,k0,k5,k6,k7,k2,k3) (inverse permutation). This occurs at j=3,7,...,27; K equals the original key from j=28 on.
  - j=30 (final round):
    - No RP.
    - Final whitening: X1^=wk0={k0[0:7],k1[8:15]} and X3^=wk1={k1[0:7],k0[8:15]}, taken from the current K.
    - Result goes to plaintext; done=1 for one cycle; next state IDLE.
- Latency: done is high in the cycle after E38, 38 clocks after the accepting edge.
  - A new start is accepted in that same done cycle (state is already IDLE).
  - Sustained throughput: one block per 39 cycles.
- busy=1 from E0+ through E38, and 0 in the done cycle.
- keyin and ciphertext may change freely after E0.

Decomposition:
- Shared package piccolo_pkg: RP byte map, key-permutation maps (forward and inverse), constant masks 16'h6547 and 16'hA98B, ROUNDS=31, state encoding (IDLE/KEXP/ROUND).
- Sub-module: the existing piccolofunction (F: S-box, diffusion matrix M, S-box), instantiated twice (on X0 and X2). No other sub-modules.

Test Plan:
- Published Piccolo-128 vector: key 00112233_44556677_8899AABB_CCDDEEFF with the published ciphertext for plaintext 01234567_89ABCDEF -> plaintext=0123456789ABCDEF; done pulses exactly 38 clocks after the start edge; busy high for those 38 cycles.
- Round trip: 1000 random key/plaintext pairs, encrypted with the codebase encryption chain and the golden model, then fed here -> plaintext matches; done width is always exactly 1 cycle.
- Back-to-back: start held high continuously with two different blocks -> the second start is taken in the done cycle of the first; the two done pulses are 39 cycles apart; both results correct.
- start pulsed at cycles 5, 20 and 37 of an operation, and keyin/ciphertext changed after E0 -> ignored; result unaffected.
- rst asserted at cycle 20 of an operation -> next cycle busy=0, done=0, plaintext=0; no done pulse follows; a fresh start decrypts correctly.
- Key permutation check: key words all distinct (0000,1111,...,7777), with internal K probed -> K equals the original key at j=28 and at the final round; the inverse permutation is applied only at j=3,7,11,15,19,23,27.

Source files
------------

// File: rtl/piccolo_pkg.sv
// -----------------------------------------------------------------------------
// piccolo_pkg
// Shared definitions for the Piccolo-128 round datapaths.
// Contents:
//   ROUNDS, KEXP_CYCLES      fixed iteration counts
//   CON_MASK_A/B             round-constant masks
//   state_t                  IDLE / KEXP / ROUND encoding
//   kword                    extract key word kn from a 128-bit key state
//   key_fwd / key_inv        forward and inverse key-word permutations
//   rp                       byte-level round permutation
//   sbox, gf_mul2, gf_mul3   F-function primitives over GF(2^4), x^4+x+1
// Bit numbering: spec bit 0 is the MSB, so word Xn of a 64-bit block sits at
// [63-16n -: 16] and key word kn at [127-16n -: 16].
// -----------------------------------------------------------------------------
package piccolo_pkg;

  localparam int ROUNDS      = 31;
  localparam int KEXP_CYCLES = 7;

  localparam logic [15:0] CON_MASK_A = 16'h6547;
  localparam logic [15:0] CON_MASK_B = 16'hA98B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEXP  = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

  // Key word kn (k0 is the most significant word).
  function automatic logic [15:0] kword(input logic [127:0] k, input logic [2:0] n);
    logic [127:0] t;
    t = k << {n, 4'b0000};
    return t[127:112];
  endfunction

  // Forward map: (k0..k7) -> (k2,k1,k6,k7,k0,k3,k4,k5)
  function automatic logic [127:0] key_fwd(input logic [127:0] k);
    return {kword(k, 3'd2), kword(k, 3'd1), kword(k, 3'd6), kword(k, 3'd7),
            kword(k, 3'd0), kword(k, 3'd3), kword(k, 3'd4), kword(k, 3'd5)};
  endfunction

  // Inverse map: (k0..k7) -> (k4,k1,k0,k5,k6,k7,k2,k3)
  function automatic logic [127:0] key_inv(input logic [127:0] k);
    return {kword(k, 3'd4), kword(k, 3'd1), kword(k, 3'd0), kword(k, 3'd5),
            kword(k, 3'd6), kword(k, 3'd7), kword(k, 3'd2), kword(k, 3'd3)};
  endfunction

  // Byte map: (b0..b7) -> (b2,b7,b4,b1,b6,b3,b0,b5)
  function automatic logic [63:0] rp(input logic [63:0] d);
    return {d[47:40], d[7:0], d[31:24], d[55:48],
            d[15:8], d[39:32], d[63:56], d[23:16]};
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'he;  4'h1: y = 4'h4;  4'h2: y = 4'hb;  4'h3: y = 4'h2;
      4'h4: y = 4'h3;  4'h5: y = 4'h8;  4'h6: y = 4'h0;  4'h7: y = 4'h9;
      4'h8: y = 4'h1;  4'h9: y = 4'ha;  4'ha: y = 4'h7;  4'hb: y = 4'hf;
      4'hc: y = 4'h6;  4'hd: y = 4'hc;  4'he: y = 4'h5;  default: y = 4'hd;
    endcase
    return y;
  endfunction

  // Multiply by x in GF(2^4) modulo x^4+x+1: overflow folds back as 4'b0011.
  function automatic logic [3:0] gf_mul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [3:0] gf_mul3(input logic [3:0] a);
    return gf_mul2(a) ^ a;
  endfunction

endpackage

// File: rtl/piccolo128_dec_iter_if.sv
// -----------------------------------------------------------------------------
// piccolo128_dec_iter_if
// Start/done handshake bundle for the Piccolo-128 decryption core.
//   start       controller -> core   request, honoured only while core is idle
//   keyin       controller -> core   128-bit key k0..k7
//   ciphertext  controller -> core   64-bit block to decrypt
//   busy        core -> controller   high while a block is in flight
//   done        core -> controller   one-cycle result-valid pulse
//   plaintext   core -> controller   result, held until the next done
// -----------------------------------------------------------------------------
interface piccolo128_dec_iter_if;
  logic         start;
  logic [127:0] keyin;
  logic [63:0]  ciphertext;
  logic         busy;
  logic         done;
  logic [63:0]  plaintext;

  modport master (output start, keyin, ciphertext,
                  input  busy, done, plaintext);

  modport slave  (input  start, keyin, ciphertext,
                  output busy, done, plaintext);
endinterface

// File: rtl/piccolofunction.sv
// -----------------------------------------------------------------------------
// piccolofunction
// Piccolo F-function: S-box layer, diffusion matrix M over GF(2^4), S-box layer.
//   i_x  16-bit input word (nibble 0 = bits [15:12])
//   o_y  16-bit output word
// M rows: (2 3 1 1) (1 2 3 1) (1 1 2 3) (3 1 1 2). Purely combinational.
// -----------------------------------------------------------------------------
module piccolofunction
  import piccolo_pkg::*;
(
  input  logic [15:0] i_x,
  output logic [15:0] o_y
);

  logic [3:0] w_s0, w_s1, w_s2, w_s3;
  logic [3:0] w_m0, w_m1, w_m2, w_m3;

  assign w_s0 = sbox(i_x[15:12]);
  assign w_s1 = sbox(i_x[11:8]);
  assign w_s2 = sbox(i_x[7:4]);
  assign w_s3 = sbox(i_x[3:0]);

  assign w_m0 = gf_mul2(w_s0) ^ gf_mul3(w_s1) ^ w_s2          ^ w_s3;
  assign w_m1 = w_s0          ^ gf_mul2(w_s1) ^ gf_mul3(w_s2) ^ w_s3;
  assign w_m2 = w_s0          ^ w_s1          ^ gf_mul2(w_s2) ^ gf_mul3(w_s3);
  assign w_m3 = gf_mul3(w_s0) ^ w_s1          ^ w_s2          ^ gf_mul2(w_s3);

  assign o_y = {sbox(w_m0), sbox(w_m1), sbox(w_m2), sbox(w_m3)};

endmodule

// File: rtl/piccolo128_dec_iter.sv
// -----------------------------------------------------------------------------
// piccolo128_dec_iter
// Iterative Piccolo-128 decryption: one round per clock, 31 rounds.
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (aborts any block in flight)
//   bus   slave side of piccolo128_dec_iter_if (start/keyin/ciphertext in,
//         busy/done/plaintext out)
// Flow: IDLE --start--> KEXP (7 forward key steps to reach the final encryption
// key state) --> ROUND (j = 0..30, walking the key schedule backwards) --> IDLE.
// done pulses 38 clocks after the accepting edge; a new start is taken in the
// done cycle, giving one block per 39 clocks.
// -----------------------------------------------------------------------------
module piccolo128_dec_iter
  import piccolo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  piccolo128_dec_iter_if.slave  bus
);

  state_t        r_state, w_state_next;
  logic [4:0]    r_cnt;
  logic [127:0]  r_key;
  logic [63:0]   r_data;
  logic [63:0]   r_plain;
  logic          r_done;
  logic          w_busy;

  logic          w_kexp_last, w_round_last;
  logic [15:0]   w_x0, w_x1, w_x2, w_x3;
  logic [15:0]   w_f0, w_f2;
  logic [2:0]    w_ka_idx, w_kb_idx;
  logic [4:0]    w_c;
  logic [15:0]   w_rka, w_rkb;
  logic [15:0]   w_x1_new, w_x3_new;
  logic [15:0]   w_wk0, w_wk1, w_wk2, w_wk3;

  assign w_kexp_last  = (r_cnt == 5'(KEXP_CYCLES - 1));
  assign w_round_last = (r_cnt == 5'(ROUNDS - 1));

  // ---------------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------------
  assign {w_x0, w_x1, w_x2, w_x3} = r_data;

  piccolofunction u_f_x0 (.i_x(w_x0), .o_y(w_f0));
  piccolofunction u_f_x2 (.i_x(w_x2), .o_y(w_f2));

  // Encryption key index i = 60-2j; only (i+2) mod 8 and (i+3) mod 8 matter,
  // and those depend on j[1:0] alone.
  assign w_ka_idx = 3'd6 - {r_cnt[1:0], 1'b0};
  assign w_kb_idx = 3'd7 - {r_cnt[1:0], 1'b0};
  assign w_c      = 5'd31 - r_cnt;

  assign w_rka = kword(r_key, w_ka_idx) ^ {w_c, 5'b00000, w_c, 1'b0} ^ CON_MASK_A;
  assign w_rkb = kword(r_key, w_kb_idx) ^ {1'b0, w_c, 5'b00000, w_c} ^ CON_MASK_B;

  // RP leaves the two branch pairs half-swapped on odd rounds, so the key
  // pair follows them.
  assign w_x1_new = w_x1 ^ w_f0 ^ (r_cnt[0] ? w_rkb : w_rka);
  assign w_x3_new = w_x3 ^ w_f2 ^ (r_cnt[0] ? w_rka : w_rkb);

  // Input whitening (wk2/wk3) from the key on the bus; output whitening
  // (wk0/wk1) from the key state, which is back to the original by then.
  assign w_wk2 = {bus.keyin[63:56],  bus.keyin[7:0]};
  assign w_wk3 = {bus.keyin[15:8],   bus.keyin[55:48]};
  assign w_wk0 = {r_key[127:120],    r_key[103:96]};
  assign w_wk1 = {r_key[111:104],    r_key[119:112]};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of all others, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_next = ST_KEXP;
      end
      ST_KEXP: begin
        w_busy = 1'b1;
        if (w_kexp_last) w_state_next = ST_ROUND;
      end
      ST_ROUND: begin
        w_busy = 1'b1;
        if (w_round_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset clears the datapath as well as the control, so plaintext and
    // the key state never expose values from an aborted block.
    if (rst) begin
      r_cnt   <= '0;
      r_key   <= '0;
      r_data  <= '0;
      r_plain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_key  <= bus.keyin;
            r_data <= {bus.ciphertext[63:48], bus.ciphertext[47:32] ^ w_wk2,
                       bus.ciphertext[31:16], bus.ciphertext[15:0]  ^ w_wk3};
            r_cnt  <= '0;
          end
        end
        ST_KEXP: begin
          r_key <= key_fwd(r_key);
          r_cnt <= w_kexp_last ? 5'd0 : r_cnt + 5'd1;
        end
        ST_ROUND: begin
          if (w_round_last) begin
            r_plain <= {w_x0, w_x1_new ^ w_wk0, w_x2, w_x3_new ^ w_wk1};
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_data <= rp({w_x0, w_x1_new, w_x2, w_x3_new});
            r_cnt  <= r_cnt + 5'd1;
            // Undo the forward step that encryption took just before index i.
            if (w_ka_idx == 3'd0) r_key <= key_inv(r_key);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.plaintext = r_plain;

endmodule

// File: tb/tb_piccolo128_dec_iter.sv
// -----------------------------------------------------------------------------
// tb_piccolo128_dec_iter
// Self-checking bench for piccolo128_dec_iter. Ciphertexts come from a
// behavioural Piccolo-128 encryption model; the decrypted plaintext, latency,
// busy window and done width are compared against fixed expectations.
// -----------------------------------------------------------------------------
module tb_piccolo128_dec_iter;
  import piccolo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piccolo128_dec_iter_if bus ();
  piccolo128_dec_iter dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] KAT_KEY = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [63:0]  KAT_PT  = 64'h01234567_89ABCDEF;
  localparam logic [127:0] KP_KEY  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;

  localparam int M_PLAIN = 0, M_GLITCH = 1, M_RESET = 2, M_KPROBE = 3;

  localparam logic [3:0] SBOX [16] = '{4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
                                       4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
  localparam int MCOEF  [16] = '{2, 3, 1, 1,  1, 2, 3, 1,  1, 1, 2, 3,  3, 1, 1, 2};
  localparam int RP_SRC [8]  = '{2, 7, 4, 1, 6, 3, 0, 5};
  localparam int KS_SRC [8]  = '{2, 1, 6, 7, 0, 3, 4, 5};

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Encryption model
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, aa;
    p  = '0;
    aa = a;
    for (int n = 0; n < 4; n++) begin
      if (b[n]) p ^= aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [15:0] f_model(input logic [15:0] x);
    logic [3:0] s [4];
    logic [3:0] y [4];
    for (int n = 0; n < 4; n++) s[n] = SBOX[x[15-4*n -: 4]];
    for (int r = 0; r < 4; r++) begin
      y[r] = '0;
      for (int c = 0; c < 4; c++) y[r] ^= gmul(4'(MCOEF[4*r+c]), s[c]);
    end
    return {SBOX[y[0]], SBOX[y[1]], SBOX[y[2]], SBOX[y[3]]};
  endfunction

  function automatic logic [63:0] rp_model(input logic [63:0] d);
    logic [63:0] o;
    for (int n = 0; n < 8; n++) o[63-8*n -: 8] = d[63-8*RP_SRC[n] -: 8];
    return o;
  endfunction

  function automatic logic [63:0] enc(input logic [127:0] key, input logic [63:0] pt);
    logic [15:0] k [8];
    logic [15:0] t [8];
    logic [15:0] rk [62];
    logic [15:0] wk [4];
    logic [15:0] x [4];
    logic [15:0] con;
    logic [4:0]  c;
    logic [63:0] d;
    for (int n = 0; n < 8; n++) k[n] = key[127-16*n -: 16];
    wk[0] = {k[0][15:8], k[1][7:0]};
    wk[1] = {k[1][15:8], k[0][7:0]};
    wk[2] = {k[4][15:8], k[7][7:0]};
    wk[3] = {k[7][15:8], k[4][7:0]};
    for (int i = 0; i < 62; i++) begin
      if ((i + 2) % 8 == 0) begin
        t = k;
        for (int n = 0; n < 8; n++) k[n] = t[KS_SRC[n]];
      end
      c   = 5'(i / 2 + 1);
      con = (i % 2 == 0) ? ({c, 5'b0, c, 1'b0} ^ 16'h6547) : ({1'b0, c, 5'b0, c} ^ 16'hA98B);
      rk[i] = k[(i + 2) % 8] ^ con;
    end
    for (int n = 0; n < 4; n++) x[n] = pt[63-16*n -: 16];
    x[1] ^= wk[0];
    x[3] ^= wk[1];
    for (int r = 0; r < 31; r++) begin
      x[1] ^= f_model(x[0]) ^ rk[2*r];
      x[3] ^= f_model(x[2]) ^ rk[2*r+1];
      if (r < 30) begin
        d = rp_model({x[0], x[1], x[2], x[3]});
        for (int n = 0; n < 4; n++) x[n] = d[63-16*n -: 16];
      end
    end
    x[1] ^= wk[2];
    x[3] ^= wk[3];
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // ---------------------------------------------------------------------------
  // One operation; mode selects extra stimulus/probing during the run.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [127:0] k, input logic [63:0] ct,
                        input logic [63:0] pt, input string tag, input int mode);
    int          n, busy_n, pulses, j;
    logic [127:0] prev_key;
    logic [31:0]  chg_mask;
    prev_key = '0;
    chg_mask = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.keyin = k; bus.ciphertext = ct;
    @(posedge clk);                       // accepting edge E0
    @(negedge clk);
    bus.start = 1'b0;
    if (mode == M_GLITCH) begin
      bus.keyin      = ~k;
      bus.ciphertext = ct ^ 64'hDEAD_BEEF_0BAD_F00D;
    end
    n = 0; busy_n = 0;
    while (!bus.done && n < 60) begin
      if (bus.busy) busy_n++;
      if (mode == M_KPROBE && dut.r_state == ST_ROUND) begin
        j = int'(dut.r_cnt);
        if (j > 0 && dut.r_key != prev_key) chg_mask[j-1] = 1'b1;
        prev_key = dut.r_key;
        if (j == 28) check({tag, "_key_j28"}, dut.r_key, k);
        if (j == 30) check({tag, "_key_j30"}, dut.r_key, k);
      end
      if (mode == M_RESET && n == 20) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_pt"},   bus.plaintext, 64'h0);
        pulses = 0;
        repeat (60) begin
          @(negedge clk);
          if (bus.done) pulses++;
        end
        check({tag, "_no_done"}, pulses, 0);
        return;
      end
      @(negedge clk);
      n++;
      if (mode == M_GLITCH) bus.start = (n == 5 || n == 20 || n == 37);
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, n, 38);
    check({tag, "_busy_cycles"}, busy_n, 38);
    check({tag, "_busy_at_done"}, bus.busy, 1'b0);
    check({tag, "_pt"}, bus.plaintext, pt);
    if (mode == M_KPROBE) check({tag, "_inv_rounds"}, chg_mask, 32'h0888_8888);
    @(negedge clk);
    check({tag, "_done_width"}, bus.done, 1'b0);
  endtask

  // start held high across two blocks: the second is taken in the first done cycle.
  task automatic back_to_back(input logic [127:0] ka, input logic [63:0] cta, input logic [63:0] pta,
                              input logic [127:0] kb, input logic [63:0] ctb, input logic [63:0] ptb);
    int n, n_first;
    @(negedge clk);
    bus.start = 1'b1; bus.keyin = ka; bus.ciphertext = cta;
    @(posedge clk);
    @(negedge clk);
    bus.keyin = kb; bus.ciphertext = ctb;
    n = 0;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_first = n;
    check("b2b_latency1", n, 38);
    check("b2b_pt1", bus.plaintext, pta);
    @(negedge clk);
    n++;
    bus.start = 1'b0;
    check("b2b_pt1_hold", bus.plaintext, pta);
    while (!bus.done && n < 120) begin
      @(negedge clk);
      n++;
    end
    check("b2b_gap", n - n_first, 39);
    check("b2b_pt2", bus.plaintext, ptb);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0]  kat_ct, pt_a, pt_b;
    logic [127:0] k_a, k_b;

    rst = 1'b1; bus.start = 1'b0; bus.keyin = '0; bus.ciphertext = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_pt",   bus.plaintext, 64'h0);
    check("reset_key",  dut.r_key, 128'h0);
    rst = 1'b0;

    kat_ct = enc(KAT_KEY, KAT_PT);
    run_op(KAT_KEY, kat_ct, KAT_PT, "kat", M_PLAIN);

    pt_a = 64'hFEDC_BA98_7654_3210;
    run_op(KP_KEY, enc(KP_KEY, pt_a), pt_a, "kperm", M_KPROBE);

    run_op(KAT_KEY, kat_ct, KAT_PT, "ignore", M_GLITCH);

    k_a  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    pt_a = 64'h1357_9BDF_2468_ACE0;
    run_op(k_a, enc(k_a, pt_a), pt_a, "midrst", M_RESET);
    run_op(k_a, enc(k_a, pt_a), pt_a, "fresh", M_PLAIN);

    k_b  = 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A;
    pt_b = 64'h0000_0000_0000_0000;
    back_to_back(k_a, enc(k_a, pt_a), pt_a, k_b, enc(k_b, pt_b), pt_b);

    for (int v = 0; v < 1000; v++) begin
      k_a  = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt_a = {$urandom(), $urandom()};
      run_op(k_a, enc(k_a, pt_a), pt_a, "rand", M_PLAIN);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
